// File: rtl/dm_resp.sv
// Single-port word memory with a fixed request-to-ack latency, byte-enabled writes
// and an out-of-range flag; one request is in flight at a time.
module dm_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  count_q;
    logic        reqWe_q;
    logic [31:0] reqAddr_q;
    logic [3:0]  reqBe_q;
    logic [31:0] reqWdata_q;
    logic        busy_q;
    logic        ack_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [WORDS];

    logic [31:0] srcAddr;
    logic        srcWe;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        latchedOor;
    logic        unusedAddrBits;

    // Response values are computed from the live inputs when LATENCY=1 sends us
    // straight from IDLE to RESP, otherwise from the fields latched at accept.
    always_comb begin
        srcAddr = reqAddr_q;
        srcWe   = reqWe_q;
        if (state_q == IDLE) begin
            srcAddr = addr;
            srcWe   = we;
        end
        err_d   = |srcAddr[31:DEPTH_LOG2+2];
        rdata_d = '0;
        if (!srcWe && !err_d) begin
            rdata_d = mem_q[srcAddr[DEPTH_LOG2+1:2]];
        end
    end

    assign latchedOor     = |reqAddr_q[31:DEPTH_LOG2+2];
    assign unusedAddrBits = &{1'b0, reqAddr_q[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reqWe_q    <= 1'b0;
            reqAddr_q  <= '0;
            reqBe_q    <= '0;
            reqWdata_q <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        reqWe_q    <= we;
                        reqAddr_q  <= addr;
                        reqBe_q    <= be;
                        reqWdata_q <= wdata;
                        count_q    <= 4'(LATENCY - 1);
                        busy_q     <= 1'b1;
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= err_d;
                            rdata_q <= rdata_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_q <= 4'd1) begin
                        state_q <= RESP;
                        count_q <= '0;
                        ack_q   <= 1'b1;
                        err_q   <= err_d;
                        rdata_q <= rdata_d;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    // Writes land on the edge that leaves RESP, so a read issued after ack sees them.
                    if (reqWe_q && !latchedOor) begin
                        for (int b = 0; b < 4; b++) begin
                            if (reqBe_q[b]) begin
                                mem_q[reqAddr_q[DEPTH_LOG2+1:2]][8*b +: 8] <= reqWdata_q[8*b +: 8];
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: one instance at LATENCY=2 and one at LATENCY=1,
// with hand-computed expected values checked inline by each scenario task.
module tb_dm_resp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        reqA = 1'b0, weA = 1'b0;
    logic [31:0] addrA = '0, wdataA = '0;
    logic [3:0]  beA = '0;
    logic        busyA, ackA, errA;
    logic [31:0] rdataA;

    logic        reqB = 1'b0, weB = 1'b0;
    logic [31:0] addrB = '0, wdataB = '0;
    logic [3:0]  beB = '0;
    logic        busyB, ackB, errB;
    logic [31:0] rdataB;

    int vectors = 0;
    int miscompares = 0;

    dm_resp #(.DEPTH_LOG2(10), .LATENCY(2)) dutA (
        .clk(clk), .reset(reset), .req(reqA), .we(weA), .addr(addrA), .be(beA),
        .wdata(wdataA), .busy(busyA), .ack(ackA), .rdata(rdataA), .err(errA)
    );

    dm_resp #(.DEPTH_LOG2(10), .LATENCY(1)) dutB (
        .clk(clk), .reset(reset), .req(reqB), .we(weB), .addr(addrB), .be(beB),
        .wdata(wdataB), .busy(busyB), .ack(ackB), .rdata(rdataB), .err(errB)
    );

    always #5 clk = ~clk;

    // Issues one request from IDLE (called at posedge+1) and follows it to its ack.
    // Inputs are scrambled right after accept so latching is exercised every time.
    task automatic applyStimulus(input bit sel, input bit w, input logic [31:0] a,
                                 input logic [3:0] b, input logic [31:0] d,
                                 output int lat, output logic [31:0] rd, output logic er,
                                 output bit gotAck, output bit busyOk, output logic ackAfter);
        if (sel) begin
            reqB = 1'b1; weB = w; addrB = a; beB = b; wdataB = d;
        end else begin
            reqA = 1'b1; weA = w; addrA = a; beA = b; wdataA = d;
        end
        @(posedge clk); #1;
        reqA = 1'b0; weA = ~w; addrA = ~a; beA = ~b; wdataA = ~d;
        reqB = 1'b0; weB = ~w; addrB = ~a; beB = ~b; wdataB = ~d;
        lat = 1;
        busyOk = 1'b1;
        while (((sel ? ackB : ackA) !== 1'b1) && lat < 20) begin
            if ((sel ? busyB : busyA) !== 1'b1) busyOk = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if ((sel ? busyB : busyA) !== 1'b1) busyOk = 1'b0;
        gotAck = ((sel ? ackB : ackA) === 1'b1);
        rd = sel ? rdataB : rdataA;
        er = sel ? errB : errA;
        @(posedge clk); #1;
        ackAfter = sel ? ackB : ackA;
        weA = 1'b0; addrA = '0; beA = '0; wdataA = '0;
        weB = 1'b0; addrB = '0; beB = '0; wdataB = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqA = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++; if (busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busyA); end
        vectors++; if (ackA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack got %b want 0", ackA); end
        vectors++; if (errA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got %b want 0", errA); end
        vectors++; if (rdataA !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata got %h want 0", rdataA); end
        vectors++; if (busyB !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busyB got %b want 0", busyB); end
        reset = 1'b0;
        reqA = 1'b0;
        @(posedge clk); #1;
        vectors++; if (busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_idle got %b want 0", busyA); end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic er, aa; bit got, bok;
        applyStimulus(1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 2) begin miscompares++; $display("[TB] FAIL wr_latency got %0d (ack %b) want 2", lat, got); end
        vectors++; if (rd !== 32'h0 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_resp got rdata %h err %b want 0/0", rd, er); end
        vectors++; if (aa !== 1'b0 || !bok) begin miscompares++; $display("[TB] FAIL wr_pulse got ackAfter %b busyOk %b want 0/1", aa, bok); end
        applyStimulus(1'b0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 2) begin miscompares++; $display("[TB] FAIL rd_latency got %0d (ack %b) want 2", lat, got); end
        vectors++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_data got %h err %b want deadbeef/0", rd, er); end
        vectors++; if (aa !== 1'b0 || rdataA !== 32'h0) begin miscompares++; $display("[TB] FAIL rd_after got ack %b rdata %h want 0/0", aa, rdataA); end
    endtask

    task automatic test_byte_merge();
        int lat; logic [31:0] rd; logic er, aa; bit got, bok;
        applyStimulus(1'b0, 1'b1, 32'h11, 4'b0010, 32'h0000AA00, lat, rd, er, got, bok, aa);
        vectors++; if (!got || er !== 1'b0) begin miscompares++; $display("[TB] FAIL merge_wr got ack %b err %b want 1/0", got, er); end
        applyStimulus(1'b0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (rd !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL merge_rd got %h want deadaaef", rd); end
        applyStimulus(1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 2 || er !== 1'b0) begin miscompares++; $display("[TB] FAIL be0_ack got ack %b lat %0d err %b want 1/2/0", got, lat, er); end
        applyStimulus(1'b0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (rd !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL be0_rd got %h want deadaaef", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er, aa; bit got, bok;
        logic [31:0] expWord;
        applyStimulus(1'b0, 1'b0, 32'h00001000, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 2) begin miscompares++; $display("[TB] FAIL oor_rd_ack got %0d (ack %b) want 2", lat, got); end
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL oor_rd got err %b rdata %h want 1/0", er, rd); end
        applyStimulus(1'b0, 1'b1, 32'h00001010, 4'b1111, 32'hCAFEF00D, lat, rd, er, got, bok, aa);
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL oor_wr got err %b rdata %h want 1/0", er, rd); end
        for (int i = 0; i < 1024; i++) begin
            expWord = (i == 4) ? 32'hDEADAAEF : 32'h0;
            applyStimulus(1'b0, 1'b0, 32'(i * 4), 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
            vectors++;
            if (rd !== expWord || er !== 1'b0 || !got) begin
                miscompares++;
                $display("[TB] FAIL scan_word%0d got %h err %b want %h/0", i, rd, er, expWord);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic expAck [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic expBusy [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        reqA = 1'b1; weA = 1'b0; addrA = 32'h10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (ackA !== expAck[i] || busyA !== expBusy[i]) begin
                miscompares++;
                $display("[TB] FAIL b2b_edge%0d got ack %b busy %b want %b/%b", i, ackA, busyA, expAck[i], expBusy[i]);
            end
            if (i == 1 || i == 4) begin
                vectors++;
                if (rdataA !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL b2b_rdata%0d got %h want deadaaef", i, rdataA); end
            end
        end
        reqA = 1'b0; addrA = '0;
        @(posedge clk); #1;
        vectors++; if (ackA !== 1'b0 || busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_end got ack %b busy %b want 0/0", ackA, busyA); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er, aa; bit got, bok;
        bit sawAck = 1'b0;
        reqA = 1'b1; weA = 1'b1; addrA = 32'h20; beA = 4'b1111; wdataA = 32'h12345678;
        @(posedge clk); #1;
        reqA = 1'b0;
        vectors++; if (busyA !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_wait got busy %b want 1", busyA); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        weA = 1'b0; addrA = '0; beA = '0; wdataA = '0;
        for (int i = 0; i < 4; i++) begin
            if (ackA === 1'b1) sawAck = 1'b1;
            @(posedge clk); #1;
        end
        vectors++; if (sawAck || busyA !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_noack got ack %b busy %b want 0/0", sawAck, busyA); end
        applyStimulus(1'b0, 1'b0, 32'h20, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (!got || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_rd got %h (ack %b) want 0", rd, got); end
        applyStimulus(1'b0, 1'b0, 32'h10, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL abort_cleared got %h want 0", rd); end
    endtask

    task automatic test_latency_one();
        int lat; logic [31:0] rd; logic er, aa; bit got, bok;
        applyStimulus(1'b1, 1'b1, 32'h4, 4'b1111, 32'h0000FFFF, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 1) begin miscompares++; $display("[TB] FAIL lat1_wr got %0d (ack %b) want 1", lat, got); end
        vectors++; if (aa !== 1'b0 || busyB !== 1'b0) begin miscompares++; $display("[TB] FAIL lat1_pulse got ack %b busy %b want 0/0", aa, busyB); end
        applyStimulus(1'b1, 1'b0, 32'h4, 4'b0000, 32'h0, lat, rd, er, got, bok, aa);
        vectors++; if (!got || lat != 1) begin miscompares++; $display("[TB] FAIL lat1_rd got %0d (ack %b) want 1", lat, got); end
        vectors++; if (rd !== 32'h0000FFFF || er !== 1'b0) begin miscompares++; $display("[TB] FAIL lat1_data got %h err %b want 0000ffff/0", rd, er); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_byte_merge();
        test_out_of_range();
        test_back_to_back();
        test_reset_abort();
        test_latency_one();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
